// File: rtl/codebreaker_multi_timer_pkg.sv
// Shared register map and bit positions for the codebreaker multi-channel timer.
package codebreaker_timer_pkg;

  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_PERIOD   = 3'd2,
    REG_SNAP     = 3'd3,
    REG_PRESCALE = 3'd4,
    REG_COUNT    = 3'd5
  } reg_off_e;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

  // Channel-index field width; a single-channel build still needs a 1-bit index.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/codebreaker_multi_timer_if.sv
// Avalon-MM slave bus of the multi-channel timer; word address is {channel, reg[2:0]}.
interface codebreaker_multi_timer_if #(
  parameter int NUM_CH = 4
);
  localparam int AW = 3 + $clog2(NUM_CH);

  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/codebreaker_multi_timer_channel.sv
// One timer channel: period/prescale/control/snapshot registers, prescaler and down-counter.
module codebreaker_timer_channel
  import codebreaker_timer_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 8,
  parameter int RESET_PERIOD = 49999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_status,
  input  logic             wr_control,
  input  logic             wr_period,
  input  logic             wr_snap,
  input  logic             wr_prescale,
  input  logic [31:0]      writedata,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] counter,
  output logic [CNT_W-1:0] snapshot,
  output logic [PRE_W-1:0] prescale,
  output logic             ito,
  output logic             cont,
  output logic             run,
  output logic             to
);

  localparam logic [CNT_W-1:0] RST_P = CNT_W'(RESET_PERIOD);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic             timeout;
  logic             start;
  logic             stop;

  assign tick    = run && (pre_cnt == prescale);
  assign timeout = tick && (counter == '0);
  assign start   = wr_control && writedata[CTL_START];
  assign stop    = wr_control && writedata[CTL_STOP] && !writedata[CTL_START];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period   <= RST_P;
      prescale <= '0;
      ito      <= 1'b0;
      cont     <= 1'b0;
      snapshot <= '0;
    end else begin
      if (wr_period)   period   <= writedata[CNT_W-1:0];
      if (wr_prescale) prescale <= writedata[PRE_W-1:0];
      if (wr_control) begin
        ito  <= writedata[CTL_ITO];
        cont <= writedata[CTL_CONT];
      end
      // Sampled before this cycle's tick, so a coincident tick never skews the capture.
      if (wr_snap)     snapshot <= counter;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= RST_P;
      pre_cnt <= '0;
      run     <= 1'b0;
    end else if (wr_period) begin
      counter <= writedata[CNT_W-1:0];
      pre_cnt <= '0;
      run     <= 1'b0;
    end else begin
      if (tick) counter <= timeout ? period : counter - CNT_W'(1);
      pre_cnt <= (!run || tick) ? '0 : pre_cnt + PRE_W'(1);
      if (timeout) run <= cont;
      // Software START/STOP override the timeout's own RUN update.
      if (start && !run) run <= 1'b1;
      else if (stop)     run <= 1'b0;
    end
  end

  // A timeout in the same cycle as a STATUS write wins, so no event is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          to <= 1'b0;
    else if (timeout)   to <= 1'b1;
    else if (wr_status) to <= 1'b0;
  end

endmodule

// File: rtl/codebreaker_multi_timer.sv
// Multi-channel interval timer: address decode, registered read mux and IRQ combine
// around NUM_CH independent timer channels.
module codebreaker_multi_timer
  import codebreaker_timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int PRE_W        = 8,
  parameter int RESET_PERIOD = 49999
) (
  input  logic                      clk,
  input  logic                      reset,
  codebreaker_multi_timer_if.slave  bus,
  output logic [NUM_CH-1:0]         irq_vec,
  output logic                      irq
);

  localparam int CH_W  = ch_idx_w(NUM_CH);
  localparam int AW    = 3 + $clog2(NUM_CH);
  localparam int NSLOT = 1 << CH_W;

  logic [2:0]      reg_off;
  logic [CH_W-1:0] ch_idx;
  logic            bus_wr;
  logic [31:0]     ch_rd [NSLOT];
  logic [31:0]     rd_next;

  assign reg_off = bus.address[2:0];
  assign bus_wr  = bus.chipselect & ~bus.write_n;

  if (NUM_CH > 1) begin : g_idx
    assign ch_idx = bus.address[AW-1:3];
  end else begin : g_idx_single
    assign ch_idx = '0;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             sel;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] snapshot;
    logic [PRE_W-1:0] prescale;
    logic             ito;
    logic             cont;
    logic             run;
    logic             to;
    logic [31:0]      rd;

    assign sel = bus_wr && (ch_idx == CH_W'(i));

    codebreaker_timer_channel #(
      .CNT_W        (CNT_W),
      .PRE_W        (PRE_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .wr_status   (sel && (reg_off == REG_STATUS)),
      .wr_control  (sel && (reg_off == REG_CONTROL)),
      .wr_period   (sel && (reg_off == REG_PERIOD)),
      .wr_snap     (sel && (reg_off == REG_SNAP)),
      .wr_prescale (sel && (reg_off == REG_PRESCALE)),
      .writedata   (bus.writedata),
      .period      (period),
      .counter     (counter),
      .snapshot    (snapshot),
      .prescale    (prescale),
      .ito         (ito),
      .cont        (cont),
      .run         (run),
      .to          (to)
    );

    always_comb begin
      rd = '0;
      case (reg_off)
        REG_STATUS: begin
          rd[ST_RUN] = run;
          rd[ST_TO]  = to;
        end
        REG_CONTROL: begin
          rd[CTL_CONT] = cont;
          rd[CTL_ITO]  = ito;
        end
        REG_PERIOD:   rd[CNT_W-1:0] = period;
        REG_SNAP:     rd[CNT_W-1:0] = snapshot;
        REG_PRESCALE: rd[PRE_W-1:0] = prescale;
        REG_COUNT:    rd[CNT_W-1:0] = counter;
        default:      rd = '0;
      endcase
    end

    assign ch_rd[i]   = rd;
    assign irq_vec[i] = to & ito;
  end

  // Unpopulated channel slots read as zero and, having no channel, ignore writes.
  for (genvar j = NUM_CH; j < NSLOT; j++) begin : g_pad
    assign ch_rd[j] = '0;
  end

  assign rd_next = ch_rd[ch_idx];
  assign irq     = |irq_vec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.readdata <= '0;
    else       bus.readdata <= rd_next;
  end

endmodule

// File: tb/tb_codebreaker_multi_timer.sv
// Directed bench for codebreaker_multi_timer: a default 4-channel instance plus a
// 5-channel, 16-bit instance for out-of-range channel and width handling.
module tb_codebreaker_multi_timer;

  logic clk;
  logic reset;
  logic [3:0] irq_vec1;
  logic       irq1;
  logic [4:0] irq_vec2;
  logic       irq2;

  int checks;
  int errors;

  codebreaker_multi_timer_if #(.NUM_CH(4)) bus1 ();
  codebreaker_multi_timer_if #(.NUM_CH(5)) bus2 ();

  codebreaker_multi_timer dut1 (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus1),
    .irq_vec (irq_vec1),
    .irq     (irq1)
  );

  codebreaker_multi_timer #(
    .NUM_CH       (5),
    .CNT_W        (16),
    .PRE_W        (8),
    .RESET_PERIOD (1000)
  ) dut2 (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus2),
    .irq_vec (irq_vec2),
    .irq     (irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All bus tasks are entered on a falling edge and return on the next one.
  task automatic wr1(input int a, input logic [31:0] d);
    bus1.address    = 5'(a);
    bus1.writedata  = d;
    bus1.chipselect = 1'b1;
    bus1.write_n    = 1'b0;
    @(negedge clk);
    bus1.chipselect = 1'b0;
    bus1.write_n    = 1'b1;
  endtask

  task automatic rchk1(input string tag, input int a, input logic [31:0] exp);
    bus1.address = 5'(a);
    @(negedge clk);
    chk(tag, bus1.readdata, exp);
  endtask

  task automatic wr2(input int a, input logic [31:0] d);
    bus2.address    = 6'(a);
    bus2.writedata  = d;
    bus2.chipselect = 1'b1;
    bus2.write_n    = 1'b0;
    @(negedge clk);
    bus2.chipselect = 1'b0;
    bus2.write_n    = 1'b1;
  endtask

  task automatic rchk2(input string tag, input int a, input logic [31:0] exp);
    bus2.address = 6'(a);
    @(negedge clk);
    chk(tag, bus2.readdata, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus1.address = '0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.writedata = '0;
    bus2.address = '0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_readdata", bus1.readdata, 0);
    chk("rst_irq", {31'd0, irq1}, 0);
    chk("rst_irq_vec", {28'd0, irq_vec1}, 0);
    rchk1("rst_ch0_count", 5, 49999);
    rchk1("rst_ch0_period", 2, 49999);
    rchk1("rst_ch0_status", 0, 0);

    // ch1: period 4, prescale 0, START|CONT|ITO -> TO five cycles after start
    wr1(10, 4);
    wr1(12, 0);
    wr1(9, 7);
    repeat (4) @(negedge clk);
    chk("ch1_irq_before", {31'd0, irq_vec1[1]}, 0);
    @(negedge clk);
    chk("ch1_irq_rise", {31'd0, irq_vec1[1]}, 1);
    chk("ch1_irq_or", {31'd0, irq1}, 1);
    rchk1("ch1_reload", 13, 4);
    rchk1("ch1_status", 8, 3);
    rchk1("ch1_running", 13, 2);
    wr1(8, 0);
    chk("ch1_irq_clr", {31'd0, irq_vec1[1]}, 0);
    chk("ch1_irq_or_clr", {31'd0, irq1}, 0);
    wr1(9, 8);
    wr1(8, 0);
    rchk1("ch1_stopped", 8, 0);
    rchk1("ch1_stop_cnt", 13, 4);

    // ch2: one-shot, period 2, prescale 3 -> timeout 12 cycles after start
    wr1(18, 2);
    wr1(20, 3);
    wr1(17, 4);
    repeat (11) @(negedge clk);
    rchk1("ch2_status_pre", 16, 2);
    rchk1("ch2_status_to", 16, 1);
    rchk1("ch2_count", 21, 2);
    chk("ch2_irq_vec", {28'd0, irq_vec1}, 0);
    rchk1("ch2_prescale", 20, 3);

    // ch0: period write while running stops and reloads; START beats STOP
    wr1(1, 6);
    repeat (3) @(negedge clk);
    wr1(2, 10);
    rchk1("ch0_pw_status", 0, 0);
    rchk1("ch0_pw_count", 5, 10);
    rchk1("ch0_pw_period", 2, 10);
    wr1(1, 12);
    rchk1("ch0_start_wins", 0, 2);
    wr1(3, 0);
    rchk1("ch0_snap", 3, 9);
    rchk1("ch0_control", 1, 0);
    rchk1("ch0_reserved6", 6, 0);
    rchk1("ch0_reserved7", 7, 0);

    // ch3: period 0, continuous -> timeout every cycle; STATUS write collides
    wr1(26, 0);
    wr1(25, 7);
    chk("ch3_irq_start", {28'd0, irq_vec1}, 0);
    @(negedge clk);
    chk("ch3_irq_set", {28'd0, irq_vec1}, 32'h8);
    wr1(24, 0);
    chk("ch3_to_kept", {28'd0, irq_vec1}, 32'h8);
    chk("ch3_irq_kept", {31'd0, irq1}, 1);
    wr1(25, 8);
    chk("ch3_irq_off", {31'd0, irq1}, 0);

    // ch2 still holds TO from its one-shot; enabling ITO exposes it
    wr1(17, 11);
    chk("ch2_ito_vec", {28'd0, irq_vec1}, 32'h4);
    chk("ch2_ito_irq", {31'd0, irq1}, 1);
    rchk1("ch2_control", 17, 3);
    wr1(16, 0);
    chk("ch2_irq_clr", {31'd0, irq1}, 0);

    // 5-channel instance: channel index 5 is out of range
    wr2(42, 7);
    for (int c = 0; c < 5; c++) rchk2($sformatf("oor_ch%0d_period", c), c * 8 + 2, 1000);
    rchk2("oor_ch5_period", 42, 0);
    rchk2("oor_ch5_count", 45, 0);
    wr2(34, 32'h12345);
    rchk2("w16_period", 34, 32'h2345);
    rchk2("w16_count", 37, 32'h2345);

    // asynchronous reset mid-count with ch3 interrupting
    wr1(26, 0);
    wr1(25, 7);
    bus1.address = 5'd2;
    @(negedge clk);
    chk("pre_rst_irq", {31'd0, irq1}, 1);
    chk("pre_rst_rd", bus1.readdata, 10);
    #2 reset = 1'b1;
    #1;
    chk("async_irq", {31'd0, irq1}, 0);
    chk("async_rd", bus1.readdata, 0);
    @(negedge clk);
    reset = 1'b0;
    rchk1("post_rst_period", 26, 49999);
    rchk1("post_rst_count", 29, 49999);
    rchk1("post_rst_status", 24, 0);
    rchk1("post_rst_ch0_per", 2, 49999);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
